// File: rtl/datapath_param_if.sv
// Controller-to-datapath bundle: strobes, bus selects and addresses in; registered state out.
// Latency: none of its own; it carries signals only.
// Backpressure: none. The controller drives strobes every cycle and the datapath always accepts them.
interface datapath_param_if #(
    parameter int DW  = 16,
    parameter int RAW = 3
);
    logic [DW-1:0]  mem_rdata;
    logic [4:0]     drv;
    logic           ldMAR, ldMDR, ldIR, ldPC, ldSP, ldReg, ldALUreg;
    logic           mdr_src, pc_inc, sp_push, sp_pop, err_clr;
    logic [RAW-1:0] rs, rd;
    logic [2:0]     fnSelect;
    logic [DW-1:0]  addr_bus, mem_wdata, ir;
    logic [3:0]     ir_op;
    logic [2:0]     ir_fn;
    logic [3:0]     flags;
    logic           bus_conflict, sp_ovf, sp_unf;

    // The controller drives strobes and observes the datapath state.
    modport master (
        output mem_rdata, drv, ldMAR, ldMDR, ldIR, ldPC, ldSP, ldReg, ldALUreg,
               mdr_src, pc_inc, sp_push, sp_pop, err_clr, rs, rd, fnSelect,
        input  addr_bus, mem_wdata, ir, ir_op, ir_fn, flags, bus_conflict, sp_ovf, sp_unf
    );
    // The datapath consumes strobes and publishes its registered state.
    modport slave (
        input  mem_rdata, drv, ldMAR, ldMDR, ldIR, ldPC, ldSP, ldReg, ldALUreg,
               mdr_src, pc_inc, sp_push, sp_pop, err_clr, rs, rd, fnSelect,
        output addr_bus, mem_wdata, ir, ir_op, ir_fn, flags, bus_conflict, sp_ovf, sp_unf
    );
endinterface

// File: rtl/datapath_param.sv
// Single-bus multicycle datapath: MAR/MDR/IR/PC/SP, register file, ALU with flags, sticky errors.
// Latency: every load takes effect at the next posedge. All outputs come straight from registers.
// Backpressure: none. Strobes are obeyed every cycle; illegal stack moves and bus conflicts only raise flags.
module datapath_param #(
    parameter int            DW      = 16,
    parameter int            NREG    = 8,
    parameter logic [DW-1:0] PC_INIT = '0,
    parameter logic [DW-1:0] SP_INIT = {DW{1'b1}},
    parameter logic [DW-1:0] SP_MIN  = {{(DW-8){1'b1}}, 8'h00}
) (
    input logic              clk,
    input logic              rst_n,
    datapath_param_if.slave  dp
);
    localparam int RAW = $clog2(NREG);

    logic [DW-1:0] r_mar, r_mdr, r_ir, r_pc, r_sp, r_alu;
    logic [DW-1:0] r_regs [NREG];
    logic [3:0]    r_flags;
    logic          r_bus_conflict, r_sp_ovf, r_sp_unf;

    logic [DW-1:0] w_bus, w_a, w_res, w_sp_nxt;
    logic [DW:0]   w_wide;
    logic          w_c, w_v, w_conflict, w_ovf_evt, w_unf_evt;

    // Bus mux: the lowest set driver bit wins, and an empty select reads as zero.
    always_comb begin
        w_bus = '0;
        if      (dp.drv[0]) w_bus = r_mdr;
        else if (dp.drv[1]) w_bus = r_pc;
        else if (dp.drv[2]) w_bus = r_sp;
        else if (dp.drv[3]) w_bus = r_regs[dp.rs];
        else if (dp.drv[4]) w_bus = r_alu;
    end

    // Clearing the lowest set bit leaves a nonzero value only when two or more drivers are on.
    assign w_conflict = |(dp.drv & (dp.drv - 5'd1));
    assign w_a        = r_regs[dp.rs];

    // ALU: A comes from the register file and B from the bus. C and V are meaningful only for arithmetic and shifts.
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (dp.fnSelect)
            3'b000: begin
                w_wide = {1'b0, w_a} + {1'b0, w_bus};
                w_res  = w_wide[DW-1:0];
                w_c    = w_wide[DW];
                w_v    = (w_a[DW-1] == w_bus[DW-1]) && (w_res[DW-1] != w_a[DW-1]);
            end
            3'b001: begin
                w_wide = {1'b0, w_a} - {1'b0, w_bus};
                w_res  = w_wide[DW-1:0];
                w_c    = w_wide[DW];
                w_v    = (w_a[DW-1] != w_bus[DW-1]) && (w_res[DW-1] != w_a[DW-1]);
            end
            3'b010: w_res = w_a & w_bus;
            3'b011: w_res = w_a | w_bus;
            3'b100: w_res = w_a ^ w_bus;
            3'b101: w_res = ~w_a;
            3'b110: begin
                w_res = {w_a[DW-2:0], 1'b0};
                w_c   = w_a[DW-1];
            end
            default: begin
                w_res = {1'b0, w_a[DW-1:1]};
                w_c   = w_a[0];
            end
        endcase
    end

    // Stack pointer next value: a load wins; a lone push or pop moves SP unless it would cross a limit.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        if (dp.ldSP) begin
            w_sp_nxt = w_bus;
        end else if (dp.sp_push && !dp.sp_pop) begin
            if (r_sp == SP_MIN) w_ovf_evt = 1'b1;
            else                w_sp_nxt  = r_sp - 1'b1;
        end else if (dp.sp_pop && !dp.sp_push) begin
            if (r_sp == SP_INIT) w_unf_evt = 1'b1;
            else                 w_sp_nxt  = r_sp + 1'b1;
        end
    end

    // Architectural registers and flags. Each load samples the bus as it was before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mar   <= '0;
            r_mdr   <= '0;
            r_ir    <= '0;
            r_alu   <= '0;
            r_flags <= '0;
            r_pc    <= PC_INIT;
            r_sp    <= SP_INIT;
        end else begin
            if (dp.ldMAR) r_mar <= w_bus;
            if (dp.ldMDR) r_mdr <= dp.mdr_src ? w_bus : dp.mem_rdata;
            if (dp.ldIR)  r_ir  <= w_bus;
            if (dp.ldPC)        r_pc <= w_bus;
            else if (dp.pc_inc) r_pc <= r_pc + 1'b1;
            r_sp <= w_sp_nxt;
            if (dp.ldALUreg) begin
                r_alu   <= w_res;
                r_flags <= {(w_res == '0), w_res[DW-1], w_c, w_v};
            end
        end
    end

    // Register file write. A same-cycle read of the written entry still sees the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (dp.ldReg) begin
            r_regs[dp.rd] <= w_bus;
        end
    end

    // Sticky error flags. A new event in the same cycle overrides err_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus_conflict <= 1'b0;
            r_sp_ovf       <= 1'b0;
            r_sp_unf       <= 1'b0;
        end else begin
            r_bus_conflict <= w_conflict | (r_bus_conflict & ~dp.err_clr);
            r_sp_ovf       <= w_ovf_evt  | (r_sp_ovf       & ~dp.err_clr);
            r_sp_unf       <= w_unf_evt  | (r_sp_unf       & ~dp.err_clr);
        end
    end

    assign dp.addr_bus     = r_mar;
    assign dp.mem_wdata    = r_mdr;
    assign dp.ir           = r_ir;
    assign dp.ir_op        = r_ir[DW-1:DW-4];
    assign dp.ir_fn        = r_ir[2:0];
    assign dp.flags        = r_flags;
    assign dp.bus_conflict = r_bus_conflict;
    assign dp.sp_ovf       = r_sp_ovf;
    assign dp.sp_unf       = r_sp_unf;
endmodule
